// File: rtl/regfile_pkg.sv
// Shared widths, requester count and grant encoding for the register-file write arbiter.
package regfile_pkg;

  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned ADDR_WIDTH  = 4;
  localparam int unsigned NUM_REQ     = 3;
  localparam int unsigned COUNT_WIDTH = 16;
  localparam int unsigned ID_WIDTH    = 2;

  typedef enum logic [ID_WIDTH-1:0] {
    GRANT_REQ0 = 2'd0,
    GRANT_REQ1 = 2'd1,
    GRANT_REQ2 = 2'd2
  } grantId_e;

  // Modulo-3 successor of a requester index.
  function automatic logic [ID_WIDTH-1:0] nextIdx(input logic [ID_WIDTH-1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin grant starting at rrPtr; grant is one-hot or zero.
module rr_arbiter3
  import regfile_pkg::*;
(
  input  logic [NUM_REQ-1:0]  reqValid,
  input  logic [ID_WIDTH-1:0] rrPtr,
  input  logic                enable,
  output logic [NUM_REQ-1:0]  grant
);

  logic [ID_WIDTH-1:0] idx;
  logic                found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = rrPtr;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (enable && !found && reqValid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
      idx = nextIdx(idx);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates three write requesters onto one registered RegisterFile write port,
// counting transfers and flagging same-address collisions.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [2:0]            reqValid,
  input  logic [ADDR_WIDTH-1:0] reqAddr0,
  input  logic [ADDR_WIDTH-1:0] reqAddr1,
  input  logic [ADDR_WIDTH-1:0] reqAddr2,
  input  logic [DATA_WIDTH-1:0] reqData0,
  input  logic [DATA_WIDTH-1:0] reqData1,
  input  logic [DATA_WIDTH-1:0] reqData2,
  output logic [2:0]            reqReady,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] writeAddr,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic [1:0]            grantId,
  output logic [15:0]           writeCount,
  output logic                  collision
);

  import regfile_pkg::*;

  logic [ID_WIDTH-1:0]   rrPtr;
  logic [NUM_REQ-1:0]    grant;
  logic                  transfer;
  grantId_e              winnerId;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selData;
  logic                  collisionNow;

  // Reset also masks the grant so reqReady is low while rst is held.
  rr_arbiter3 uArb (
    .reqValid (reqValid),
    .rrPtr    (rrPtr),
    .enable   (enable & ~rst),
    .grant    (grant)
  );

  assign reqReady = grant;
  assign transfer = |(grant & reqValid);

  always_comb begin
    winnerId = GRANT_REQ0;
    selAddr  = reqAddr0;
    selData  = reqData0;
    if (grant[1]) begin
      winnerId = GRANT_REQ1;
      selAddr  = reqAddr1;
      selData  = reqData1;
    end else if (grant[2]) begin
      winnerId = GRANT_REQ2;
      selAddr  = reqAddr2;
      selData  = reqData2;
    end
  end

  assign collisionNow = (reqValid[0] && reqValid[1] && (reqAddr0 == reqAddr1)) ||
                        (reqValid[0] && reqValid[2] && (reqAddr0 == reqAddr2)) ||
                        (reqValid[1] && reqValid[2] && (reqAddr1 == reqAddr2));

  // Capture register, round-robin pointer, transfer counter and sticky collision flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      writeEnable <= 1'b0;
      writeAddr   <= '0;
      writeData   <= '0;
      grantId     <= '0;
      rrPtr       <= '0;
      writeCount  <= '0;
      collision   <= 1'b0;
    end else begin
      writeEnable <= transfer;
      if (transfer) begin
        writeAddr  <= selAddr;
        writeData  <= selData;
        grantId    <= winnerId;
        rrPtr      <= nextIdx(winnerId);
        writeCount <= writeCount + 16'd1;
      end
      if (collisionNow) begin
        collision <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural RegisterFile on the write port.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  reqValid;
  logic [3:0]  reqAddr0, reqAddr1, reqAddr2;
  logic [15:0] reqData0, reqData1, reqData2;
  logic [2:0]  reqReady;
  logic        writeEnable;
  logic [3:0]  writeAddr;
  logic [15:0] writeData;
  logic [1:0]  grantId;
  logic [15:0] writeCount;
  logic        collision;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] rf [16];

  regfile_write_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .reqValid    (reqValid),
    .reqAddr0    (reqAddr0),
    .reqAddr1    (reqAddr1),
    .reqAddr2    (reqAddr2),
    .reqData0    (reqData0),
    .reqData1    (reqData1),
    .reqData2    (reqData2),
    .reqReady    (reqReady),
    .writeEnable (writeEnable),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .grantId     (grantId),
    .writeCount  (writeCount),
    .collision   (collision)
  );

  always #5 clk = ~clk;

  // RegisterFile commits on the edge after writeEnable is presented.
  always @(posedge clk) begin
    if (writeEnable) rf[writeAddr] <= writeData;
  end

  task automatic doReset();
    rst = 1'b1;
    reqValid = 3'b000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    reqValid = 3'b111;
    reqAddr0 = 4'd0; reqAddr1 = 4'd0; reqAddr2 = 4'd0;
    reqData0 = 16'h0; reqData1 = 16'h0; reqData2 = 16'h0;
    @(negedge clk);
    vectors++;
    if (reqReady !== 3'b000 || writeEnable !== 1'b0 || writeAddr !== 4'd0 || writeData !== 16'h0 ||
        grantId !== 2'd0 || writeCount !== 16'd0 || collision !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b we=%b addr=%h data=%h id=%0d cnt=%h col=%b, required all zero",
               reqReady, writeEnable, writeAddr, writeData, grantId, writeCount, collision);
    end
    reqValid = 3'b000;
    rst = 1'b0;
  endtask

  task automatic test_single();
    doReset();
    reqValid = 3'b001; reqAddr0 = 4'd2; reqData0 = 16'h1234;
    #1;
    vectors++;
    if (reqReady !== 3'b001) begin
      errors++; $display("FAIL single_ready: got %b required 001", reqReady);
    end
    @(negedge clk);
    reqValid = 3'b000;
    vectors++;
    if (writeEnable !== 1'b1 || writeAddr !== 4'd2 || writeData !== 16'h1234 || grantId !== 2'd0 ||
        writeCount !== 16'd1) begin
      errors++;
      $display("FAIL single_write: we=%b addr=%0d data=%h id=%0d cnt=%0d required 1/2/1234/0/1",
               writeEnable, writeAddr, writeData, grantId, writeCount);
    end
    @(negedge clk);
    vectors++;
    if (rf[2] !== 16'h1234 || writeEnable !== 1'b0) begin
      errors++; $display("FAIL single_commit: reg2=%h we=%b required 1234/0", rf[2], writeEnable);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  expAddr [3];
    logic [15:0] expData [3];
    logic [2:0]  expRdy;
    expAddr[0] = 4'd3; expAddr[1] = 4'd4; expAddr[2] = 4'd5;
    expData[0] = 16'h1111; expData[1] = 16'h2222; expData[2] = 16'h3333;
    doReset();
    reqValid = 3'b111;
    reqAddr0 = 4'd3; reqAddr1 = 4'd4; reqAddr2 = 4'd5;
    reqData0 = 16'h1111; reqData1 = 16'h2222; reqData2 = 16'h3333;
    for (int c = 0; c < 3; c++) begin
      #1;
      expRdy = 3'b001 << c;
      vectors++;
      if (reqReady !== expRdy) begin
        errors++; $display("FAIL rr_ready_%0d: got %b required %b", c, reqReady, expRdy);
      end
      @(negedge clk);
      vectors++;
      if (writeEnable !== 1'b1 || grantId !== 2'(c) || writeAddr !== expAddr[c] || writeData !== expData[c]) begin
        errors++;
        $display("FAIL rr_write_%0d: we=%b id=%0d addr=%0d data=%h required 1/%0d/%0d/%h",
                 c, writeEnable, grantId, writeAddr, writeData, c, expAddr[c], expData[c]);
      end
    end
    reqValid = 3'b000;
    vectors++;
    if (writeCount !== 16'd3) begin
      errors++; $display("FAIL rr_count: got %0d required 3", writeCount);
    end
    @(negedge clk);
    vectors++;
    if (writeEnable !== 1'b0 || writeAddr !== 4'd5 || writeData !== 16'h3333 || grantId !== 2'd2) begin
      errors++;
      $display("FAIL idle_hold: we=%b addr=%0d data=%h id=%0d required 0/5/3333/2",
               writeEnable, writeAddr, writeData, grantId);
    end
  endtask

  task automatic test_collision();
    doReset();
    reqValid = 3'b011;
    reqAddr0 = 4'd0; reqAddr1 = 4'd0;
    reqData0 = 16'habcd; reqData1 = 16'h5555;
    #1;
    vectors++;
    if (reqReady !== 3'b001) begin
      errors++; $display("FAIL col_ready0: got %b required 001", reqReady);
    end
    @(negedge clk);
    reqValid = 3'b010;
    vectors++;
    if (collision !== 1'b1 || grantId !== 2'd0 || writeData !== 16'habcd || writeAddr !== 4'd0) begin
      errors++;
      $display("FAIL col_first: col=%b id=%0d data=%h addr=%0d required 1/0/abcd/0",
               collision, grantId, writeData, writeAddr);
    end
    #1;
    vectors++;
    if (reqReady !== 3'b010) begin
      errors++; $display("FAIL col_ready1: got %b required 010", reqReady);
    end
    @(negedge clk);
    reqValid = 3'b000;
    vectors++;
    if (grantId !== 2'd1 || writeData !== 16'h5555 || rf[0] !== 16'habcd) begin
      errors++;
      $display("FAIL col_second: id=%0d data=%h reg0=%h required 1/5555/abcd", grantId, writeData, rf[0]);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (collision !== 1'b1 || rf[0] !== 16'h5555) begin
      errors++; $display("FAIL col_sticky: col=%b reg0=%h required 1/5555", collision, rf[0]);
    end
  endtask

  task automatic test_enable();
    doReset();
    enable = 1'b0;
    reqValid = 3'b111;
    reqAddr0 = 4'd8; reqAddr1 = 4'd9; reqAddr2 = 4'd10;
    #1;
    vectors++;
    if (reqReady !== 3'b000) begin
      errors++; $display("FAIL en_off_ready: got %b required 000", reqReady);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (writeEnable !== 1'b0 || writeCount !== 16'd0) begin
      errors++; $display("FAIL en_off_write: we=%b cnt=%0d required 0/0", writeEnable, writeCount);
    end
    enable = 1'b1;
    #1;
    vectors++;
    if (reqReady !== 3'b001) begin
      errors++; $display("FAIL en_on_ready: got %b required 001", reqReady);
    end
    @(negedge clk);
    enable = 1'b0;
    #1;
    vectors++;
    if (writeEnable !== 1'b1 || grantId !== 2'd0 || reqReady !== 3'b000) begin
      errors++;
      $display("FAIL en_captured: we=%b id=%0d rdy=%b required 1/0/000", writeEnable, grantId, reqReady);
    end
    reqValid = 3'b000;
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] prev;
    doReset();
    prev = rf[7];
    reqValid = 3'b001; reqAddr0 = 4'd7; reqData0 = prev ^ 16'hbeef;
    @(posedge clk);
    #1;
    vectors++;
    if (writeEnable !== 1'b1 || writeCount !== 16'd1) begin
      errors++; $display("FAIL mid_capture: we=%b cnt=%0d required 1/1", writeEnable, writeCount);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (writeEnable !== 1'b0 || writeCount !== 16'd0 || reqReady !== 3'b000) begin
      errors++;
      $display("FAIL mid_async: we=%b cnt=%0d rdy=%b required 0/0/000", writeEnable, writeCount, reqReady);
    end
    @(negedge clk);
    reqValid = 3'b000;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (rf[7] !== prev) begin
      errors++; $display("FAIL mid_discard: reg7=%h required %h", rf[7], prev);
    end
    reqValid = 3'b111;
    #1;
    vectors++;
    if (reqReady !== 3'b001) begin
      errors++; $display("FAIL mid_first_grant: got %b required 001", reqReady);
    end
    @(negedge clk);
    reqValid = 3'b000;
  endtask

  task automatic test_wrap();
    doReset();
    reqValid = 3'b001; reqAddr0 = 4'd1; reqData0 = 16'h0f0f;
    repeat (65535) @(negedge clk);
    vectors++;
    if (writeCount !== 16'hffff || writeEnable !== 1'b1) begin
      errors++; $display("FAIL wrap_full: cnt=%h we=%b required ffff/1", writeCount, writeEnable);
    end
    @(negedge clk);
    reqValid = 3'b000;
    vectors++;
    if (writeCount !== 16'h0000) begin
      errors++; $display("FAIL wrap_zero: cnt=%h required 0000", writeCount);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_collision();
    test_enable();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
